ped_request_latch: RTL

- Sits directly downstream of the button debouncer; consumes its synchronous debounced pedestrian-button level and turns it into a latched walk request for the traffic-light controller FSM.
- Detects press edges, holds the request until the controller grants it, and enforces a hold-off window after service.
- Flags long presses, which the controller uses as a priority/accessibility request.

---
 rtl/ped_request_latch.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ped_request_latch.sv
// Pedestrian request latch: turns the debounced button level into a held walk
// request, enforces a post-service hold-off and flags long presses.
module ped_request_latch #(
    parameter int HOLDOFF   = 27,
    parameter int LONGPRESS = 100,
    parameter int CW        = 19
) (
    input  logic clock,
    input  logic reset,
    input  logic clean,
    input  logic grant,
    output logic press_pulse,
    output logic req,
    output logic long_press,
    output logic busy,
    output logic dropped
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PENDING,
        S_SERVING,
        S_HOLD
    } state_t;

    localparam logic [CW-1:0] HO_LAST = (HOLDOFF == 0) ? '0 : CW'(HOLDOFF - 1);
    localparam logic [CW-1:0] LP_MAX  = CW'(LONGPRESS);

    state_t        state_q, state_d;
    logic          clean_dly_q, clean_dly_d;
    logic          press_pulse_q, press_pulse_d;
    logic          req_q, req_d;
    logic          long_press_q, long_press_d;
    logic          busy_q, busy_d;
    logic          dropped_q, dropped_d;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] lcnt_q, lcnt_d;
    logic          rise;

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        busy_d        = busy_q;
        hcnt_d        = hcnt_q;
        clean_dly_d   = clean;
        rise          = clean & ~clean_dly_q;
        press_pulse_d = rise && (state_q != S_HOLD);
        dropped_d     = rise && (state_q == S_HOLD);

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_PENDING;
                    req_d   = 1'b1;
                end
            end
            // Grant takes priority over a coincident re-press; nothing is queued.
            S_PENDING: begin
                if (grant) begin
                    state_d = S_SERVING;
                    req_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_SERVING: begin
                if (!grant) begin
                    if (HOLDOFF == 0) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_HOLD;
                        hcnt_d  = '0;
                    end
                end
            end
            S_HOLD: begin
                if (hcnt_q == HO_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    hcnt_d = hcnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!clean) begin
            lcnt_d = '0;
        end else if (lcnt_q != LP_MAX) begin
            lcnt_d = lcnt_q + CW'(1);
        end else begin
            lcnt_d = lcnt_q;
        end
        long_press_d = clean && (lcnt_d == LP_MAX);
    end

    // clean_dly resets high so a button held through reset is not a press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            clean_dly_q   <= 1'b1;
            press_pulse_q <= 1'b0;
            req_q         <= 1'b0;
            long_press_q  <= 1'b0;
            busy_q        <= 1'b0;
            dropped_q     <= 1'b0;
            hcnt_q        <= '0;
            lcnt_q        <= '0;
        end else begin
            state_q       <= state_d;
            clean_dly_q   <= clean_dly_d;
            press_pulse_q <= press_pulse_d;
            req_q         <= req_d;
            long_press_q  <= long_press_d;
            busy_q        <= busy_d;
            dropped_q     <= dropped_d;
            hcnt_q        <= hcnt_d;
            lcnt_q        <= lcnt_d;
        end
    end

    assign press_pulse = press_pulse_q;
    assign req         = req_q;
    assign long_press  = long_press_q;
    assign busy        = busy_q;
    assign dropped     = dropped_q;

endmodule
